// File: rtl/conv_enc_k3.sv
// Rate-1/2 K=3 convolutional encoder with automatic two-bit zero-tail frame termination.
// Latency: one cycle from input accept to symbol on out_sym_o; one symbol per cycle unstalled.
// Backpressure: single output slot; in_ready_o drops while the slot is held or during the tail.
module conv_enc_k3 #(
    parameter logic [2:0] G0      = 3'b111,
    parameter logic [2:0] G1      = 3'b101,
    parameter int         MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       in_bit_i,
    input  logic       in_last_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [1:0] out_sym_o,
    output logic       out_tail_o,
    output logic       out_last_o,
    output logic       len_err_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_TAIL1 = 2'd1,
        ST_TAIL2 = 2'd2
    } state_e;

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_e     state_q;
    logic [1:0] sr_q;
    logic [7:0] cnt_q;
    logic       out_valid_q;
    logic [1:0] out_sym_q;
    logic       out_tail_q;
    logic       out_last_q;

    logic       slot_free;
    logic       accept;
    logic       gen;
    logic       u;
    logic [8:0] cnt_inc;
    logic       hit_max;
    logic [1:0] sym_d;

    // Handshake decode, encoder input selection and parity generation.
    always_comb begin
        slot_free = !out_valid_q || out_ready_i;
        accept    = (state_q == ST_DATA) && in_valid_i && slot_free;
        // Tail states push a zero through the shift register to return it to state 00.
        gen       = accept || ((state_q != ST_DATA) && slot_free);
        u         = (state_q == ST_DATA) ? in_bit_i : 1'b0;
        cnt_inc   = {1'b0, cnt_q} + 9'd1;
        hit_max   = (cnt_inc == MAX_LEN_W);
        sym_d[1]  = ^(G0 & {u, sr_q[0], sr_q[1]});
        sym_d[0]  = ^(G1 & {u, sr_q[0], sr_q[1]});
    end

    assign in_ready_o  = (state_q == ST_DATA) && slot_free;
    assign len_err_o   = accept && !in_last_i && hit_max;
    assign busy_o      = (state_q != ST_DATA) || (cnt_q != 8'd0);
    assign out_valid_o = out_valid_q;
    assign out_sym_o   = out_sym_q;
    assign out_tail_o  = out_tail_q;
    assign out_last_o  = out_last_q;

    // Frame FSM, encoder memory and the registered output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DATA;
            sr_q        <= 2'b00;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (gen) begin
                out_valid_q <= 1'b1;
                out_sym_q   <= sym_d;
                sr_q        <= {sr_q[0], u};
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_DATA: begin
                    if (accept) begin
                        out_tail_q <= 1'b0;
                        out_last_q <= 1'b0;
                        cnt_q      <= cnt_inc[7:0];
                        if (in_last_i || hit_max) begin
                            state_q <= ST_TAIL1;
                        end
                    end
                end
                ST_TAIL1: begin
                    if (slot_free) begin
                        out_tail_q <= 1'b1;
                        out_last_q <= 1'b0;
                        state_q    <= ST_TAIL2;
                    end
                end
                ST_TAIL2: begin
                    if (slot_free) begin
                        out_tail_q <= 1'b1;
                        out_last_q <= 1'b1;
                        cnt_q      <= 8'd0;
                        state_q    <= ST_DATA;
                    end
                end
                default: begin
                    state_q <= ST_DATA;
                end
            endcase
        end
    end

endmodule
